// File: rtl/draw_scheduler.sv
// draw_scheduler
// Serialises all redraw work onto a single-cell drawer through a start/busy
// handshake. Three requesters (playhead marker, cell toggles, cursor moves)
// plus a full-screen sweep after reset or on refresh.
//
// Ports:
//   CLOCK_50            system clock, rising edge
//   Reset               synchronous active-high reset
//   tog_req/row/col     cell toggle notification (queued in a small FIFO)
//   cur_req/row/col     cursor move (coalesced, latest wins)
//   play_req/col/vis    playhead update (coalesced, latest wins)
//   refresh             request a full sweep
//   cell_row/cell_col   grid read address, cell_val is the combinational answer
//   drw_start           one-cycle draw command with drw_x/drw_y/drw_style
//   drw_busy            drawer busy
//   sched_busy          scheduler active or work pending
//   tog_drop            toggle lost because the FIFO was full
module draw_scheduler #(
  parameter int GRID_SIZE   = 12,
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       CLOCK_50,
  input  logic       Reset,
  input  logic       tog_req,
  input  logic [3:0] tog_row,
  input  logic [3:0] tog_col,
  input  logic       cur_req,
  input  logic [3:0] cur_row,
  input  logic [3:0] cur_col,
  input  logic       play_req,
  input  logic [3:0] play_col,
  input  logic       play_vis,
  input  logic       refresh,
  output logic [3:0] cell_row,
  output logic [3:0] cell_col,
  input  logic       cell_val,
  output logic       drw_start,
  output logic [3:0] drw_x,
  output logic [3:0] drw_y,
  output logic [2:0] drw_style,
  input  logic       drw_busy,
  output logic       sched_busy,
  output logic       tog_drop
);

  localparam logic [3:0] MARK_ROW = 4'(GRID_SIZE);
  localparam logic [3:0] LAST_COL = 4'(GRID_SIZE - 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [AW-1:0] ACK_LAST = AW'(ACK_TIMEOUT - 1);
  localparam logic [AW-1:0] ACK_ONE = AW'(1);

  typedef enum logic [2:0] {
    ST_SWEEP     = 3'd0,
    ST_IDLE      = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_DONE = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    JOB_SWEEP = 2'd0,
    JOB_PH    = 2'd1,
    JOB_TOG   = 2'd2,
    JOB_CUR   = 2'd3
  } job_t;

  state_t state_q, state_d;
  job_t   job_q, job_d;
  logic   step_q, step_d;              // second draw of a two-draw job
  logic [3:0] tgt_row_q, tgt_row_d, tgt_col_q, tgt_col_d;
  logic [3:0] sw_row_q, sw_row_d, sw_col_q, sw_col_d;
  logic [AW-1:0] ack_cnt_q, ack_cnt_d;

  logic [3:0] disp_cur_row_q, disp_cur_row_d, disp_cur_col_q, disp_cur_col_d;
  logic [3:0] disp_ph_col_q, disp_ph_col_d;
  logic       disp_ph_vis_q, disp_ph_vis_d;

  logic       sweep_pend_q, sweep_pend_d;
  logic       ph_pend_q, ph_pend_d;
  logic [3:0] ph_tgt_col_q, ph_tgt_col_d;
  logic       ph_tgt_vis_q, ph_tgt_vis_d;
  logic       cur_pend_q, cur_pend_d;
  logic [3:0] cur_tgt_row_q, cur_tgt_row_d, cur_tgt_col_q, cur_tgt_col_d;

  // Job-local copies so new requests can re-arm without disturbing the job
  logic [3:0] job_cur_row_q, job_cur_row_d, job_cur_col_q, job_cur_col_d;
  logic [3:0] job_ph_col_q, job_ph_col_d;
  logic       job_ph_vis_q, job_ph_vis_d;

  logic [7:0]    fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;

  logic       drw_start_q, drw_start_d;
  logic [3:0] drw_x_q, drw_x_d, drw_y_q, drw_y_d;
  logic [2:0] drw_style_q, drw_style_d;
  logic       sched_busy_q, sched_busy_d;
  logic       tog_drop_q, tog_drop_d;

  logic fifo_empty_s, fifo_full_s, push_s, pop_s;
  logic pick_sweep_s, pick_ph_s, pick_cur_s;
  logic draw_done_s, last_draw_s, ph_hit_s, cur_hit_s;
  logic [2:0] style_s;
  state_t after_draw_s;

  assign fifo_empty_s = (fifo_cnt_q == {CW{1'b0}});
  assign fifo_full_s  = (fifo_cnt_q == FULL_CNT);

  // Fixed-priority arbitration in IDLE: sweep, playhead, toggle, cursor
  assign pick_sweep_s = (state_q == ST_IDLE) && sweep_pend_q;
  assign pick_ph_s    = (state_q == ST_IDLE) && !sweep_pend_q && ph_pend_q;
  assign pop_s        = (state_q == ST_IDLE) && !sweep_pend_q && !ph_pend_q && !fifo_empty_s;
  assign pick_cur_s   = (state_q == ST_IDLE) && !sweep_pend_q && !ph_pend_q && fifo_empty_s && cur_pend_q;

  // A pop in the same cycle frees a slot, so a full FIFO still accepts
  assign push_s     = tog_req && (!fifo_full_s || pop_s);
  assign fifo_cnt_d = fifo_cnt_q + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};

  // A silent drawer is treated as done after ACK_TIMEOUT low cycles
  assign draw_done_s = !drw_busy && ((state_q == ST_WAIT_DONE) ||
                       ((state_q == ST_WAIT_ACK) && (ack_cnt_q == ACK_LAST)));

  assign ph_hit_s  = (tgt_col_q == disp_ph_col_q) && disp_ph_vis_q;
  assign cur_hit_s = (tgt_row_q == disp_cur_row_q) && (tgt_col_q == disp_cur_col_q);

  // Whether the draw currently in flight is the final one of its job
  always_comb begin
    case (job_q)
      JOB_SWEEP: last_draw_s = (sw_row_q == MARK_ROW) && (sw_col_q == LAST_COL);
      JOB_PH:    last_draw_s = step_q || !job_ph_vis_q;
      JOB_TOG:   last_draw_s = 1'b1;
      JOB_CUR:   last_draw_s = step_q;
      default:   last_draw_s = 1'b1;
    endcase
    if (last_draw_s) begin
      after_draw_s = ST_IDLE;
    end else if (job_q == JOB_SWEEP) begin
      after_draw_s = ST_SWEEP;
    end else begin
      after_draw_s = ST_ISSUE;
    end
  end

  // FSM state register
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state_q <= ST_SWEEP;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SWEEP: state_d = ST_ISSUE;
      ST_IDLE: begin
        if (sweep_pend_q) begin
          state_d = ST_SWEEP;
        end else if (ph_pend_q) begin
          // Hidden-to-hidden playhead update needs no draw at all
          state_d = (disp_ph_vis_q || ph_tgt_vis_q) ? ST_ISSUE : ST_IDLE;
        end else if (!fifo_empty_s || cur_pend_q) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      // Never start while the drawer still reports busy
      ST_ISSUE: state_d = drw_busy ? ST_ISSUE : ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (drw_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (draw_done_s) begin
          state_d = after_draw_s;
        end else begin
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_DONE: state_d = draw_done_s ? after_draw_s : ST_WAIT_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Job setup, draw sequencing, displayed state and request capture
  always_comb begin
    job_d          = job_q;
    step_d         = step_q;
    tgt_row_d      = tgt_row_q;
    tgt_col_d      = tgt_col_q;
    sw_row_d       = sw_row_q;
    sw_col_d       = sw_col_q;
    disp_cur_row_d = disp_cur_row_q;
    disp_cur_col_d = disp_cur_col_q;
    disp_ph_col_d  = disp_ph_col_q;
    disp_ph_vis_d  = disp_ph_vis_q;
    job_cur_row_d  = job_cur_row_q;
    job_cur_col_d  = job_cur_col_q;
    job_ph_col_d   = job_ph_col_q;
    job_ph_vis_d   = job_ph_vis_q;
    sweep_pend_d   = sweep_pend_q;
    ph_pend_d      = ph_pend_q;
    cur_pend_d     = cur_pend_q;

    if (pick_sweep_s) begin
      job_d        = JOB_SWEEP;
      sw_row_d     = 4'd0;
      sw_col_d     = 4'd0;
      sweep_pend_d = 1'b0;
    end else if (pick_ph_s) begin
      job_d        = JOB_PH;
      ph_pend_d    = 1'b0;
      job_ph_col_d = ph_tgt_col_q;
      job_ph_vis_d = ph_tgt_vis_q;
      if (disp_ph_vis_q) begin
        tgt_row_d = MARK_ROW;
        tgt_col_d = disp_ph_col_q;
        step_d    = 1'b0;
      end else if (ph_tgt_vis_q) begin
        // Nothing to erase: go straight to the show draw
        tgt_row_d = MARK_ROW;
        tgt_col_d = ph_tgt_col_q;
        step_d    = 1'b1;
      end else begin
        disp_ph_col_d = ph_tgt_col_q;
        disp_ph_vis_d = 1'b0;
      end
    end else if (pop_s) begin
      job_d     = JOB_TOG;
      step_d    = 1'b0;
      tgt_row_d = fifo_mem_q[rd_ptr_q][7:4];
      tgt_col_d = fifo_mem_q[rd_ptr_q][3:0];
    end else if (pick_cur_s) begin
      job_d         = JOB_CUR;
      step_d        = 1'b0;
      cur_pend_d    = 1'b0;
      job_cur_row_d = cur_tgt_row_q;
      job_cur_col_d = cur_tgt_col_q;
      tgt_row_d     = disp_cur_row_q;
      tgt_col_d     = disp_cur_col_q;
    end else if (state_q == ST_SWEEP) begin
      tgt_row_d = sw_row_q;
      tgt_col_d = sw_col_q;
    end else if (draw_done_s && last_draw_s) begin
      case (job_q)
        JOB_PH: begin
          disp_ph_col_d = job_ph_col_q;
          disp_ph_vis_d = job_ph_vis_q;
        end
        JOB_CUR: begin
          disp_cur_row_d = job_cur_row_q;
          disp_cur_col_d = job_cur_col_q;
        end
        default: step_d = step_q;
      endcase
    end else if (draw_done_s) begin
      case (job_q)
        JOB_SWEEP: begin
          if (sw_col_q == LAST_COL) begin
            sw_col_d = 4'd0;
            sw_row_d = sw_row_q + 4'd1;
          end else begin
            sw_col_d = sw_col_q + 4'd1;
          end
        end
        JOB_PH: begin
          tgt_row_d = MARK_ROW;
          tgt_col_d = job_ph_col_q;
          step_d    = 1'b1;
        end
        JOB_CUR: begin
          tgt_row_d = job_cur_row_q;
          tgt_col_d = job_cur_col_q;
          step_d    = 1'b1;
        end
        default: step_d = step_q;
      endcase
    end else begin
      step_d = step_q;
    end

    // Capture after job start so a same-cycle request re-arms its flag
    sweep_pend_d = sweep_pend_d | refresh;
    if (play_req) begin
      ph_pend_d    = 1'b1;
      ph_tgt_col_d = play_col;
      ph_tgt_vis_d = play_vis;
    end else begin
      ph_tgt_col_d = ph_tgt_col_q;
      ph_tgt_vis_d = ph_tgt_vis_q;
    end
    if (cur_req) begin
      cur_pend_d    = 1'b1;
      cur_tgt_row_d = cur_row;
      cur_tgt_col_d = cur_col;
    end else begin
      cur_tgt_row_d = cur_tgt_row_q;
      cur_tgt_col_d = cur_tgt_col_q;
    end
  end

  // Draw style and next values of the registered outputs
  always_comb begin
    case (job_q)
      JOB_SWEEP: begin
        if (tgt_row_q == MARK_ROW) begin
          style_s = {ph_hit_s, 2'b00};
        end else begin
          style_s = {ph_hit_s, cur_hit_s, cell_val};
        end
      end
      JOB_PH:  style_s = {step_q, 2'b00};
      JOB_TOG: style_s = {ph_hit_s, cur_hit_s, cell_val};
      JOB_CUR: style_s = {ph_hit_s, step_q, cell_val};
      default: style_s = 3'b000;
    endcase

    drw_start_d = (state_q == ST_ISSUE) && !drw_busy;
    if (drw_start_d) begin
      drw_x_d     = tgt_col_q;
      drw_y_d     = tgt_row_q;
      drw_style_d = style_s;
    end else begin
      drw_x_d     = drw_x_q;
      drw_y_d     = drw_y_q;
      drw_style_d = drw_style_q;
    end

    if (state_q == ST_ISSUE) begin
      ack_cnt_d = {AW{1'b0}};
    end else if (state_q == ST_WAIT_ACK) begin
      ack_cnt_d = ack_cnt_q + ACK_ONE;
    end else begin
      ack_cnt_d = ack_cnt_q;
    end

    tog_drop_d   = tog_req && fifo_full_s && !pop_s;
    sched_busy_d = (state_d != ST_IDLE) || sweep_pend_d || ph_pend_d ||
                   cur_pend_d || (fifo_cnt_d != {CW{1'b0}});
  end

  // Datapath, request and output registers
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      job_q          <= JOB_SWEEP;
      step_q         <= 1'b0;
      tgt_row_q      <= 4'd0;
      tgt_col_q      <= 4'd0;
      sw_row_q       <= 4'd0;
      sw_col_q       <= 4'd0;
      ack_cnt_q      <= {AW{1'b0}};
      disp_cur_row_q <= 4'd0;
      disp_cur_col_q <= 4'd0;
      disp_ph_col_q  <= 4'd0;
      disp_ph_vis_q  <= 1'b0;
      job_cur_row_q  <= 4'd0;
      job_cur_col_q  <= 4'd0;
      job_ph_col_q   <= 4'd0;
      job_ph_vis_q   <= 1'b0;
      sweep_pend_q   <= 1'b0;
      ph_pend_q      <= 1'b0;
      ph_tgt_col_q   <= 4'd0;
      ph_tgt_vis_q   <= 1'b0;
      cur_pend_q     <= 1'b0;
      cur_tgt_row_q  <= 4'd0;
      cur_tgt_col_q  <= 4'd0;
      drw_start_q    <= 1'b0;
      drw_x_q        <= 4'd0;
      drw_y_q        <= 4'd0;
      drw_style_q    <= 3'b000;
      sched_busy_q   <= 1'b1;
      tog_drop_q     <= 1'b0;
    end else begin
      job_q          <= job_d;
      step_q         <= step_d;
      tgt_row_q      <= tgt_row_d;
      tgt_col_q      <= tgt_col_d;
      sw_row_q       <= sw_row_d;
      sw_col_q       <= sw_col_d;
      ack_cnt_q      <= ack_cnt_d;
      disp_cur_row_q <= disp_cur_row_d;
      disp_cur_col_q <= disp_cur_col_d;
      disp_ph_col_q  <= disp_ph_col_d;
      disp_ph_vis_q  <= disp_ph_vis_d;
      job_cur_row_q  <= job_cur_row_d;
      job_cur_col_q  <= job_cur_col_d;
      job_ph_col_q   <= job_ph_col_d;
      job_ph_vis_q   <= job_ph_vis_d;
      sweep_pend_q   <= sweep_pend_d;
      ph_pend_q      <= ph_pend_d;
      ph_tgt_col_q   <= ph_tgt_col_d;
      ph_tgt_vis_q   <= ph_tgt_vis_d;
      cur_pend_q     <= cur_pend_d;
      cur_tgt_row_q  <= cur_tgt_row_d;
      cur_tgt_col_q  <= cur_tgt_col_d;
      drw_start_q    <= drw_start_d;
      drw_x_q        <= drw_x_d;
      drw_y_q        <= drw_y_d;
      drw_style_q    <= drw_style_d;
      sched_busy_q   <= sched_busy_d;
      tog_drop_q     <= tog_drop_d;
    end
  end

  // Toggle FIFO pointers and storage
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      fifo_cnt_q <= {CW{1'b0}};
    end else begin
      fifo_cnt_q <= fifo_cnt_d;
      if (push_s) begin
        fifo_mem_q[wr_ptr_q] <= {tog_row, tog_col};
        wr_ptr_q             <= wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_q <= wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_q <= rd_ptr_q;
      end
    end
  end

  assign cell_row   = tgt_row_q;
  assign cell_col   = tgt_col_q;
  assign drw_start  = drw_start_q;
  assign drw_x      = drw_x_q;
  assign drw_y      = drw_y_q;
  assign drw_style  = drw_style_q;
  assign sched_busy = sched_busy_q;
  assign tog_drop   = tog_drop_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed testbench for draw_scheduler: a drawer model that raises busy two
// cycles after drw_start for five cycles, a 16x16 grid model for cell_val,
// and a log of every drw_start and tog_drop seen on the falling edge.
module tb_draw_scheduler;

  logic       clk = 1'b0;
  logic       Reset;
  logic       tog_req, cur_req, play_req, play_vis, refresh;
  logic [3:0] tog_row, tog_col, cur_row, cur_col, play_col;
  logic [3:0] cell_row, cell_col, drw_x, drw_y;
  logic       cell_val, drw_start, drw_busy, sched_busy, tog_drop;
  logic [2:0] drw_style;

  logic grid [16][16];
  logic ack_en, force_busy;
  int   t = 0;
  int   cyc = 0;
  int   drops = 0;
  int   drop_cyc = -1;
  int   viol = 0;
  int   passed = 0;
  int   total = 0;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic [2:0] s;
    int         c;
  } ev_t;
  ev_t ev_q[$];
  ev_t mon_e;

  always #5 clk = ~clk;

  draw_scheduler dut (
    .CLOCK_50(clk), .Reset(Reset),
    .tog_req(tog_req), .tog_row(tog_row), .tog_col(tog_col),
    .cur_req(cur_req), .cur_row(cur_row), .cur_col(cur_col),
    .play_req(play_req), .play_col(play_col), .play_vis(play_vis),
    .refresh(refresh),
    .cell_row(cell_row), .cell_col(cell_col), .cell_val(cell_val),
    .drw_start(drw_start), .drw_x(drw_x), .drw_y(drw_y), .drw_style(drw_style),
    .drw_busy(drw_busy), .sched_busy(sched_busy), .tog_drop(tog_drop)
  );

  assign cell_val = grid[cell_row][cell_col];

  always @(posedge clk) cyc <= cyc + 1;

  // Drawer: busy in cycles S+2..S+6 for a start in cycle S
  always @(posedge clk) begin
    if (drw_start) t <= 1;
    else if (t != 0 && t < 7) t <= t + 1;
    else t <= 0;
  end
  assign drw_busy = force_busy | (ack_en & (t >= 2) & (t < 7));

  always @(negedge clk) begin
    if (drw_start) begin
      mon_e.x = drw_x; mon_e.y = drw_y; mon_e.s = drw_style; mon_e.c = cyc;
      ev_q.push_back(mon_e);
      if (drw_busy) viol++;
    end
    if (tog_drop) begin
      drops++;
      drop_cyc = cyc;
    end
  end

  function automatic ev_t get_ev(int i);
    ev_t e;
    e.x = 4'hF; e.y = 4'hF; e.s = 3'b111; e.c = -1;
    if (i < ev_q.size()) e = ev_q[i];
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    tick(2);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!sched_busy) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bit ok, bad;
    ev_t e;
    Reset = 1'b1;
    tick(3);
    @(negedge clk);
    total++; if (drw_start !== 1'b0) $display("FAIL rst_start got %b want 0", drw_start); else passed++;
    total++; if ({drw_x, drw_y} !== 8'h00) $display("FAIL rst_xy got %h want 00", {drw_x, drw_y}); else passed++;
    total++; if (drw_style !== 3'b000) $display("FAIL rst_style got %b want 000", drw_style); else passed++;
    total++; if ({cell_row, cell_col} !== 8'h00) $display("FAIL rst_cell got %h want 00", {cell_row, cell_col}); else passed++;
    total++; if (tog_drop !== 1'b0) $display("FAIL rst_drop got %b want 0", tog_drop); else passed++;
    total++; if (sched_busy !== 1'b1) $display("FAIL rst_busy got %b want 1", sched_busy); else passed++;
    @(posedge clk); #1;
    Reset = 1'b0;
    ev_q = {};
    wait_idle(3000, ok);
    total++; if (ok !== 1'b1) $display("FAIL sweep_idle got busy want idle"); else passed++;
    total++; if (ev_q.size() != 156) $display("FAIL sweep_count got %0d want 156", ev_q.size()); else passed++;
    e = get_ev(0);
    total++; if ({e.y, e.x, e.s} !== {4'd0, 4'd0, 3'b010}) $display("FAIL sweep_first got y%0d x%0d s%b want y0 x0 s010", e.y, e.x, e.s); else passed++;
    bad = 1'b0;
    for (int i = 0; i < 156; i++) begin
      e = get_ev(i);
      if (e.y != 4'(i / 12) || e.x != 4'(i % 12) || e.s != ((i == 0) ? 3'b010 : 3'b000)) bad = 1'b1;
    end
    total++; if (bad) $display("FAIL sweep_order got out-of-order draw want row-major"); else passed++;
    e = get_ev(155);
    total++; if ({e.y, e.x, e.s} !== {4'd12, 4'd11, 3'b000}) $display("FAIL sweep_last got y%0d x%0d s%b want y12 x11 s000", e.y, e.x, e.s); else passed++;
  endtask

  task automatic test_toggle;
    bit ok;
    int k;
    ev_t e;
    grid[3][5] = 1'b1;
    ev_q = {};
    tog_req = 1'b1; tog_row = 4'd3; tog_col = 4'd5; k = cyc;
    tick(1);
    tog_req = 1'b0;
    wait_idle(100, ok);
    e = get_ev(0);
    total++; if (ok !== 1'b1) $display("FAIL tog_idle got busy want idle"); else passed++;
    total++; if (ev_q.size() != 1) $display("FAIL tog_count got %0d want 1", ev_q.size()); else passed++;
    total++; if (e.c != k + 3) $display("FAIL tog_latency got %0d want %0d", e.c, k + 3); else passed++;
    total++; if ({e.y, e.x} !== {4'd3, 4'd5}) $display("FAIL tog_xy got y%0d x%0d want y3 x5", e.y, e.x); else passed++;
    total++; if (e.s !== 3'b001) $display("FAIL tog_style got %b want 001", e.s); else passed++;
  endtask

  task automatic test_cursor;
    bit ok;
    ev_t e;
    grid[4][7] = 1'b1;
    ev_q = {};
    tog_req = 1'b1; tog_row = 4'd1; tog_col = 4'd1;
    tick(1);
    tog_req = 1'b0;
    cur_req = 1'b1; cur_row = 4'd2; cur_col = 4'd2;
    tick(1);
    cur_row = 4'd4; cur_col = 4'd7;
    tick(1);
    cur_req = 1'b0;
    wait_idle(200, ok);
    tog_req = 1'b1; tog_row = 4'd4; tog_col = 4'd7;
    tick(1);
    tog_req = 1'b0;
    wait_idle(100, ok);
    tog_req = 1'b1; tog_row = 4'd0; tog_col = 4'd0;
    tick(1);
    tog_req = 1'b0;
    wait_idle(100, ok);
    total++; if (ev_q.size() != 5) $display("FAIL cur_count got %0d want 5", ev_q.size()); else passed++;
    e = get_ev(0);
    total++; if ({e.y, e.x, e.s} !== {4'd1, 4'd1, 3'b000}) $display("FAIL cur_tog got y%0d x%0d s%b want y1 x1 s000", e.y, e.x, e.s); else passed++;
    e = get_ev(1);
    total++; if ({e.y, e.x, e.s} !== {4'd0, 4'd0, 3'b000}) $display("FAIL cur_erase got y%0d x%0d s%b want y0 x0 s000", e.y, e.x, e.s); else passed++;
    e = get_ev(2);
    total++; if ({e.y, e.x, e.s} !== {4'd4, 4'd7, 3'b011}) $display("FAIL cur_draw got y%0d x%0d s%b want y4 x7 s011", e.y, e.x, e.s); else passed++;
    e = get_ev(3);
    total++; if (e.s !== 3'b011) $display("FAIL cur_disp_new got %b want 011", e.s); else passed++;
    e = get_ev(4);
    total++; if (e.s !== 3'b000) $display("FAIL cur_disp_old got %b want 000", e.s); else passed++;
  endtask

  task automatic test_priority;
    bit ok;
    int k;
    ev_t e;
    ev_q = {};
    play_req = 1'b1; play_col = 4'd3; play_vis = 1'b1;
    tog_req = 1'b1; tog_row = 4'd6; tog_col = 4'd3; k = cyc;
    tick(1);
    play_req = 1'b0; tog_req = 1'b0;
    wait_idle(200, ok);
    total++; if (ev_q.size() != 2) $display("FAIL prio_count got %0d want 2", ev_q.size()); else passed++;
    e = get_ev(0);
    total++; if ({e.y, e.x, e.s} !== {4'd12, 4'd3, 3'b100}) $display("FAIL prio_marker got y%0d x%0d s%b want y12 x3 s100", e.y, e.x, e.s); else passed++;
    total++; if (e.c != k + 3) $display("FAIL prio_latency got %0d want %0d", e.c, k + 3); else passed++;
    e = get_ev(1);
    total++; if ({e.y, e.x, e.s} !== {4'd6, 4'd3, 3'b100}) $display("FAIL prio_tog got y%0d x%0d s%b want y6 x3 s100", e.y, e.x, e.s); else passed++;
  endtask

  task automatic test_fifo_full;
    bit ok, bad;
    int k5;
    ev_t e;
    ev_q = {};
    drops = 0;
    force_busy = 1'b1;
    cur_req = 1'b1; cur_row = 4'd4; cur_col = 4'd7;
    tick(1);
    cur_req = 1'b0;
    tick(1);
    k5 = 0;
    for (int i = 0; i < 5; i++) begin
      tog_req = 1'b1; tog_row = 4'd7; tog_col = 4'(i); k5 = cyc;
      tick(1);
    end
    tog_req = 1'b0;
    tick(4);
    force_busy = 1'b0;
    wait_idle(300, ok);
    total++; if (drops != 1) $display("FAIL fifo_drops got %0d want 1", drops); else passed++;
    total++; if (drop_cyc != k5 + 1) $display("FAIL fifo_drop_cyc got %0d want %0d", drop_cyc, k5 + 1); else passed++;
    total++; if (ev_q.size() != 6) $display("FAIL fifo_count got %0d want 6", ev_q.size()); else passed++;
    e = get_ev(0);
    total++; if ({e.y, e.x, e.s} !== {4'd4, 4'd7, 3'b001}) $display("FAIL fifo_cur_erase got y%0d x%0d s%b want y4 x7 s001", e.y, e.x, e.s); else passed++;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e = get_ev(i + 2);
      if (e.y != 4'd7 || e.x != 4'(i)) bad = 1'b1;
    end
    total++; if (bad) $display("FAIL fifo_order got wrong toggle order want x0..x3 on y7"); else passed++;
    e = get_ev(5);
    total++; if (e.s !== 3'b100) $display("FAIL fifo_ph_style got %b want 100", e.s); else passed++;
  endtask

  task automatic test_timeout;
    bit ok;
    int k;
    ev_t e;
    ack_en = 1'b0;
    ev_q = {};
    tog_req = 1'b1; tog_row = 4'd8; tog_col = 4'd8; k = cyc;
    tick(1);
    tog_col = 4'd9;
    tick(1);
    tog_req = 1'b0;
    wait_idle(200, ok);
    ack_en = 1'b1;
    total++; if (ok !== 1'b1) $display("FAIL to_idle got busy want idle"); else passed++;
    total++; if (ev_q.size() != 2) $display("FAIL to_count got %0d want 2", ev_q.size()); else passed++;
    e = get_ev(0);
    total++; if (e.c != k + 3) $display("FAIL to_first got %0d want %0d", e.c, k + 3); else passed++;
    e = get_ev(1);
    total++; if (e.c != k + 20) $display("FAIL to_second got %0d want %0d", e.c, k + 20); else passed++;
    total++; if (e.x !== 4'd9) $display("FAIL to_second_x got %0d want 9", e.x); else passed++;
  endtask

  task automatic test_handshake;
    total++; if (viol != 0) $display("FAIL start_while_busy got %0d want 0", viol); else passed++;
  endtask

  initial begin
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        grid[r][c] = 1'b0;
    Reset = 1'b1;
    tog_req = 1'b0; cur_req = 1'b0; play_req = 1'b0; refresh = 1'b0;
    tog_row = 4'd0; tog_col = 4'd0; cur_row = 4'd0; cur_col = 4'd0;
    play_col = 4'd0; play_vis = 1'b0;
    ack_en = 1'b1; force_busy = 1'b0;
    test_reset;
    test_toggle;
    test_cursor;
    test_priority;
    test_fifo_full;
    test_timeout;
    test_handshake;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/draw_scheduler.md
# draw_scheduler

Sequences all redraw work onto the single-cell grid drawer (`vga_display`). Arbitrates three requesters: playhead marker, cell toggles and cursor moves. Performs a full-screen sweep after reset or on demand. Owns the displayed cursor and playhead state, reads cell contents from the grid matrix, and issues one cell draw at a time through a start/busy handshake.

## Interface
Parameters
- GRID_SIZE, 12, rows and columns of note grid; marker row index = GRID_SIZE
- FIFO_DEPTH, 4, toggle request queue depth (power of 2)
- ACK_TIMEOUT, 15, cycles to wait for drw_busy rise before abandoning a draw

Ports
- CLOCK_50  in  1  system clock; all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- tog_req  in  1  one-cycle pulse: cell (tog_row, tog_col) changed
- tog_row, tog_col  in  4 each  toggled cell
- cur_req  in  1  one-cycle pulse: cursor moved to (cur_row, cur_col)
- cur_row, cur_col  in  4 each  new cursor position
- play_req  in  1  one-cycle pulse: playhead update
- play_col  in  4  new playhead column
- play_vis  in  1  1 = marker shown, 0 = hidden
- refresh  in  1  one-cycle pulse: request full sweep
- cell_row, cell_col  out  4 each  grid read address
- cell_val  in  1  grid bit at (cell_row, cell_col), combinational
- drw_start  out  1  one-cycle draw command
- drw_x, drw_y  out  4 each  target column / row (row GRID_SIZE = marker row)
- drw_style  out  3  bit0 cell on, bit1 cursor, bit2 playhead
- drw_busy  in  1  drawer busy
- sched_busy  out  1  high whenever state ≠ IDLE or any request pending
- tog_drop  out  1  one-cycle pulse: toggle dropped, FIFO full

## Operation
- States: SWEEP, IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
- Displayed state registers:
  - disp_cur (row, col), reset (0,0)
  - disp_ph_col, reset 0
  - disp_ph_vis, reset 0
- Capture (every cycle, in every state):
  - tog_req pushes {row, col} into the FIFO. If the FIFO is full, the entry is discarded and tog_drop pulses.
  - cur_req sets cur_pend and overwrites cur_tgt (coalescing).
  - play_req sets ph_pend and overwrites ph_tgt_col/ph_tgt_vis.
  - refresh sets sweep_pend.
- IDLE arbitration, fixed priority:
  - sweep_pend, then ph_pend, then FIFO non-empty, then cur_pend.
  - The selected job loads the target and enters ISSUE (SWEEP for sweep_pend).
- Job expansion:
  - Playhead job: erase draw at (GRID_SIZE, disp_ph_col), style 000, only if disp_ph_vis = 1. Then, if ph_tgt_vis = 1, a show draw at (GRID_SIZE, ph_tgt_col), style 100. disp_ph_* updates after the last draw completes. ph_pend clears when the job starts; a new play_req during the job re-arms it.
  - Toggle job: one draw at the popped cell.
  - Cursor job: erase draw at disp_cur with bit1 = 0, then draw at cur_tgt with bit1 = 1. disp_cur updates after the second draw completes. Both draws run back-to-back with no preemption.
- Cell style for row < GRID_SIZE:
  - bit0 = cell_val.
  - bit1 = (cell == disp_cur), except as overridden by the cursor job.
  - bit2 = (col == disp_ph_col && disp_ph_vis).
- ISSUE lasts one cycle:
  - cell_row/cell_col hold the target; cell_val is sampled at the end of the cycle.
  - The next cycle asserts drw_start with drw_x/drw_y/drw_style.
- WAIT_ACK: wait for drw_busy = 1, then go to WAIT_DONE. If drw_busy stays low for ACK_TIMEOUT cycles, treat the draw as done.
- WAIT_DONE: wait for drw_busy = 0, then run the next draw of the job (back to ISSUE) or return to IDLE.
- SWEEP:
  - Draws rows 0..GRID_SIZE-1, columns 0..GRID_SIZE-1, row-major.
  - Then draws marker row columns 0..GRID_SIZE-1, each with style bit2 = (col == disp_ph_col && disp_ph_vis).
  - Total 156 draws; each draw uses the ISSUE/WAIT handshake.
  - Requests arriving during a sweep are queued.
- Reset: enter SWEEP with counters 0 and a cleared FIFO. All pend flags clear.

## Timing
- Reset values: drw_start 0, drw_x/drw_y 0, drw_style 0, cell_row/cell_col 0, tog_drop 0, sched_busy 1.
- Latency: request pulse in cycle k, idle scheduler, empty queues:
  - k+1: IDLE arbitrates.
  - k+2: ISSUE.
  - k+3: drw_start = 1.
- drw_x/drw_y/drw_style are valid with drw_start and held until the next drw_start.
- drw_start is never asserted while drw_busy = 1 or outside the cycle after ISSUE.
- Simultaneous tog_req and pop in the same cycle: legal when full; the pop frees a slot, so no drop.
- Reset asserted mid-draw: outputs return to reset values next cycle; the drawer's in-flight draw is ignored.

## Test plan
- Reset with drawer ack after 2 cycles and busy for 5 -> exactly 156 drw_start pulses in sweep order, row 0 col 0 first, marker row last, then sched_busy = 0.
- Idle scheduler, tog_req (3,5) with cell_val = 1, cursor (0,0) -> drw_start at k+3, x=5, y=3, style 001.
- cur_req to (2,2), then cur_req to (4,7) before service -> exactly two draws: (0,0) style with bit1 = 0, then (4,7) with bit1 = 1; disp_cur = (4,7).
- play_req col 3 vis 1 simultaneous with tog_req -> marker draw (12,3) style 100 issued before the toggle draw.
- Five tog_req pulses while drawer held busy -> four queued, tog_drop pulses once on the fifth.
- drw_busy never asserted -> scheduler abandons the draw after 15 cycles and proceeds to the next job.
